// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that shares one sin/cos engine among NUM_REQ requesters.
// One request in flight; each result (or timeout error) is returned to its own requester.
module cordic_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_sin,
    output logic [DATA_WIDTH-1:0]         rsp_cos,
    output logic                          rsp_err,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_angle,
    input  logic                          eng_done,
    input  logic [DATA_WIDTH-1:0]         eng_sin,
    input  logic [DATA_WIDTH-1:0]         eng_cos
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(TIMEOUT + 1);
    localparam logic [IDW:0]  NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDW-1:0]          rr_ptr_r;
    logic [IDW-1:0]          rr_ptr_next_s;
    logic [IDW-1:0]          cur_id_r;
    logic [IDW-1:0]          cur_id_next_s;
    logic [DATA_WIDTH-1:0]   cur_angle_r;
    logic [DATA_WIDTH-1:0]   cur_angle_next_s;
    logic [DATA_WIDTH-1:0]   res_sin_r;
    logic [DATA_WIDTH-1:0]   res_sin_next_s;
    logic [DATA_WIDTH-1:0]   res_cos_r;
    logic [DATA_WIDTH-1:0]   res_cos_next_s;
    logic                    err_r;
    logic                    err_next_s;
    logic [CW-1:0]           wait_cnt_r;
    logic [CW-1:0]           wait_cnt_next_s;

    logic                    grant_found_s;
    logic [IDW-1:0]          grant_id_s;
    logic [DATA_WIDTH-1:0]   grant_angle_s;

    // Requester index base+off reduced modulo NUM_REQ (both operands already below NUM_REQ).
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input logic [IDW:0]   off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            vec[i] = (id == IDW'(i));
        end
        return vec;
    endfunction

    // Round-robin search: scanned from the far end so the offset closest to rr_ptr wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[wrap_add(rr_ptr_r, (IDW+1)'(i))]) begin
                grant_found_s = 1'b1;
                grant_id_s    = wrap_add(rr_ptr_r, (IDW+1)'(i));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_angle_s = req_angle[int'(grant_id_s) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state and datapath update for the single in-flight transaction.
    always_comb begin
        state_next_s     = state_r;
        rr_ptr_next_s    = rr_ptr_r;
        cur_id_next_s    = cur_id_r;
        cur_angle_next_s = cur_angle_r;
        res_sin_next_s   = res_sin_r;
        res_cos_next_s   = res_cos_r;
        err_next_s       = err_r;
        wait_cnt_next_s  = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    cur_id_next_s    = grant_id_s;
                    cur_angle_next_s = grant_angle_s;
                    state_next_s     = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                wait_cnt_next_s = '0;
                state_next_s    = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    res_sin_next_s = eng_sin;
                    res_cos_next_s = eng_cos;
                    err_next_s     = 1'b0;
                    state_next_s   = RESP;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    // Engine never answered: return a flagged zero result instead of stalling.
                    res_sin_next_s = '0;
                    res_cos_next_s = '0;
                    err_next_s     = 1'b1;
                    state_next_s   = RESP;
                end else begin
                    wait_cnt_next_s = wait_cnt_r + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready[cur_id_r]) begin
                    rr_ptr_next_s = wrap_add(cur_id_r, (IDW+1)'(1));
                    state_next_s  = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            cur_id_r    <= '0;
            cur_angle_r <= '0;
            res_sin_r   <= '0;
            res_cos_r   <= '0;
            err_r       <= 1'b0;
            wait_cnt_r  <= '0;
        end else begin
            state_r     <= state_next_s;
            rr_ptr_r    <= rr_ptr_next_s;
            cur_id_r    <= cur_id_next_s;
            cur_angle_r <= cur_angle_next_s;
            res_sin_r   <= res_sin_next_s;
            res_cos_r   <= res_cos_next_s;
            err_r       <= err_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
        end
    end

    // Output decode; everything is forced low while rst is asserted.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        eng_start = 1'b0;
        eng_angle = '0;
        rsp_sin   = '0;
        rsp_cos   = '0;
        rsp_err   = 1'b0;
        if (!rst) begin
            eng_angle = cur_angle_r;
            rsp_sin   = res_sin_r;
            rsp_cos   = res_cos_r;
            rsp_err   = err_r;
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        req_ready = id_onehot(grant_id_s);
                    end else begin
                        req_ready = '0;
                    end
                end
                START:   eng_start = 1'b1;
                WAIT:    eng_start = 1'b0;
                RESP:    rsp_valid = id_onehot(cur_id_r);
                default: rsp_valid = '0;
            endcase
        end else begin
            req_ready = '0;
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a fixed-latency engine stub (sin = angle, cos = ~angle).
module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int TO  = 64;
    localparam int LAT = 17;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_angle;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [W-1:0]       rsp_sin;
    logic [W-1:0]       rsp_cos;
    logic               rsp_err;
    logic               eng_start;
    logic [W-1:0]       eng_angle;
    logic               eng_done;
    logic [W-1:0]       eng_sin;
    logic [W-1:0]       eng_cos;

    logic [W-1:0]       ang [N];
    logic               stub_en;
    logic               stub_done = 1'b0;
    logic               force_done;
    logic [W-1:0]       stub_ang = '0;
    int                 stub_cnt = 0;
    int                 cyc = 0;
    int                 last_done_cyc = -1;
    int                 n_vec = 0;
    int                 n_bad = 0;

    typedef struct {
        logic [N-1:0] id;
        logic [W-1:0] s;
        logic [W-1:0] c;
        logic         e;
    } exp_t;

    exp_t               sb[$];
    int                 order[$];
    exp_t               mon_e;

    cordic_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .rsp_err   (rsp_err),
        .eng_start (eng_start),
        .eng_angle (eng_angle),
        .eng_done  (eng_done),
        .eng_sin   (eng_sin),
        .eng_cos   (eng_cos)
    );

    always #5 clk = ~clk;

    assign req_angle = {ang[3], ang[2], ang[1], ang[0]};
    assign eng_done  = stub_done | force_done;
    assign eng_sin   = force_done ? 32'hDEAD_BEEF : stub_ang;
    assign eng_cos   = force_done ? 32'h1234_5678 : ~stub_ang;

    // Engine stub: ignores rst, answers LAT cycles after a sampled start when enabled.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stub_done <= 1'b0;
        if (eng_start && stub_en) begin
            stub_cnt <= LAT;
            stub_ang <= eng_angle;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pushes expectations on accepted grants, pops and compares on response handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (eng_done) last_done_cyc = cyc;
                if (req_ready != '0) begin
                    chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                    for (int k = 0; k < N; k++) begin
                        if (req_ready[k]) begin
                            chk("grant_has_valid", 64'(req_valid[k]), 64'd1);
                            order.push_back(k);
                            mon_e.id    = '0;
                            mon_e.id[k] = 1'b1;
                            mon_e.s     = stub_en ? ang[k] : 32'h0;
                            mon_e.c     = stub_en ? ~ang[k] : 32'h0;
                            mon_e.e     = ~stub_en;
                            sb.push_back(mon_e);
                        end
                    end
                end
                if ((rsp_valid & rsp_ready) != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'(sb.size()), 64'd1);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("rsp_id",  64'(rsp_valid), 64'(mon_e.id));
                        chk("rsp_sin", 64'(rsp_sin),   64'(mon_e.s));
                        chk("rsp_cos", 64'(rsp_cos),   64'(mon_e.c));
                        chk("rsp_err", 64'(rsp_err),   64'(mon_e.e));
                    end
                end
            end
        end
    end

    task automatic wait_grant(input int id, input int maxc);
        int seen;
        seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                seen = 1;
                break;
            end
        end
        chk("grant_wait", 64'(seen), 64'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int maxc, output int at);
        int seen;
        seen = 0;
        at   = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen = 1;
                at   = cyc;
                break;
            end
        end
        chk("rsp_wait", 64'(seen), 64'd1);
    endtask

    task automatic drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_req(input int id);
        @(posedge clk);
        #1 req_valid[id] = 1'b1;
        wait_grant(id, 50);
    endtask

    initial begin
        int g, s, rc, n;
        rst        = 1'b1;
        req_valid  = '1;
        rsp_ready  = '1;
        stub_en    = 1'b1;
        force_done = 1'b0;
        for (int k = 0; k < N; k++) ang[k] = 32'h1000_0000 * (k + 1) + 32'h55;

        // Reset: every output low even with all requests raised.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_eng_angle", 64'(eng_angle), 64'd0);
        chk("rst_rsp_sin",   64'(rsp_sin),   64'd0);
        chk("rst_rsp_cos",   64'(rsp_cos),   64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd0);

        // Single request from requester 2.
        ang[2] = 32'h2000_0000;
        @(posedge clk);
        #1 req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_grant", 64'(req_ready), 64'h4);
        g = cyc;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("t1_start",      64'(eng_start), 64'd1);
        chk("t1_start_lat",  64'(cyc - g),   64'd1);
        chk("t1_eng_angle",  64'(eng_angle), 64'h2000_0000);
        @(negedge clk);
        chk("t1_start_pulse", 64'(eng_start), 64'd0);
        chk("t1_angle_hold",  64'(eng_angle), 64'h2000_0000);
        wait_rsp(100, rc);
        chk("t1_rsp_lat",   64'(rc - last_done_cyc), 64'd1);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("t1_sin",       64'(rsp_sin),   64'h2000_0000);
        chk("t1_cos",       64'(rsp_cos),   64'hDFFF_FFFF);
        chk("t1_err",       64'(rsp_err),   64'd0);
        drain(10);

        // All four requesters continuously valid from reset: order 0,1,2,3,0.
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        order.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (order.size() >= 5) break;
        end
        @(posedge clk);
        #1 req_valid = '0;
        chk("t2_grants", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("t2_order", 64'(order[i]), 64'(i % N));
        drain(100);

        // Response backpressure on requester 1 while requester 0 waits.
        ang[1]    = 32'h8000_0001;
        rsp_ready = 4'b1101;
        do_req(1);
        req_valid = 4'b0001;
        wait_rsp(100, rc);
        for (int i = 0; i < 10; i++) begin
            chk("t3_rsp_valid", 64'(rsp_valid), 64'h2);
            chk("t3_sin",       64'(rsp_sin),   64'h8000_0001);
            chk("t3_cos",       64'(rsp_cos),   64'h7FFF_FFFE);
            chk("t3_no_start",  64'(eng_start), 64'd0);
            chk("t3_no_grant",  64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = '1;
        wait_grant(0, 10);
        drain(100);

        // Engine never answers: timeout response, then a normal one.
        @(posedge clk);
        #1 stub_en = 1'b0;
        ang[3] = 32'h1357_9BDF;
        do_req(3);
        @(negedge clk);
        chk("t4_start", 64'(eng_start), 64'd1);
        s = cyc;
        wait_rsp(200, rc);
        chk("t4_to_lat", 64'(rc - s),  64'(TO + 1));
        chk("t4_err",    64'(rsp_err), 64'd1);
        chk("t4_sin",    64'(rsp_sin), 64'd0);
        chk("t4_cos",    64'(rsp_cos), 64'd0);
        @(posedge clk);
        #1 stub_en = 1'b1;
        drain(10);
        ang[0] = 32'h0246_8ACE;
        do_req(0);
        wait_rsp(100, rc);
        chk("t4b_err", 64'(rsp_err), 64'd0);
        chk("t4b_sin", 64'(rsp_sin), 64'h0246_8ACE);
        drain(10);

        // Reset in the 5th WAIT cycle; the late done must be ignored.
        ang[2] = 32'h0F0F_0F0F;
        do_req(2);
        @(negedge clk);
        chk("t5_start", 64'(eng_start), 64'd1);
        s = cyc;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid != '0) n++;
        end
        chk("t5_no_rsp",    64'(n), 64'd0);
        chk("t5_done_seen", 64'(last_done_cyc > s), 64'd1);
        chk("t5_eng_angle", 64'(eng_angle), 64'd0);
        @(posedge clk);
        #1 req_valid = 4'b1001;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        chk("t5_ptr0", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_grant(3, 100);
        drain(100);

        // Spurious done while idle changes nothing.
        @(posedge clk);
        #1 force_done = 1'b1;
        @(posedge clk);
        #1 force_done = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t6_eng_start", 64'(eng_start), 64'd0);
        chk("t6_sin",       64'(rsp_sin),   64'h1357_9BDF);
        chk("t6_cos",       64'(rsp_cos),   64'hECA8_6420);
        chk("t6_err",       64'(rsp_err),   64'd0);
        chk("t6_sb",        64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
